// File: rtl/ga_pkg.sv
// Shared constants and state encoding for the genetic path optimiser stages.
package ga_pkg;

    localparam int PATH_W = 150;
    localparam int N_POP  = 50;
    localparam int N_SEL  = 10;
    localparam int COST_W = 16;
    localparam int IDX_W  = $clog2(N_POP);

    localparam logic [COST_W-1:0] COST_MAX = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_POP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/selection_if.sv
// Start/done handshake plus population and selection buses of the selector.
interface selection_if;
    import ga_pkg::*;

    logic                      start;
    logic [N_POP*PATH_W-1:0]   population;
    logic [N_POP*COST_W-1:0]   cost;
    logic [N_SEL*PATH_W-1:0]   sel_population;
    logic [N_SEL*COST_W-1:0]   sel_cost;
    logic                      done;

    modport master (
        output start, population, cost,
        input  sel_population, sel_cost, done
    );

    modport slave (
        input  start, population, cost,
        output sel_population, sel_cost, done
    );

endinterface

// File: rtl/topk_slot.sv
// One entry of the sorted top-k chain: insert candidate, shift from
// the upper neighbour, or hold.
module topk_slot
    import ga_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [COST_W-1:0] cand_cost,
    input  logic [PATH_W-1:0] cand_path,
    input  logic              prev_hit,
    input  logic              prev_valid,
    input  logic [COST_W-1:0] prev_cost,
    input  logic [PATH_W-1:0] prev_path,
    output logic              hit,
    output logic              valid,
    output logic [COST_W-1:0] cost,
    output logic [PATH_W-1:0] path
);

    logic              valid_q, valid_d;
    logic [COST_W-1:0] cost_q, cost_d;
    logic [PATH_W-1:0] path_q, path_d;

    // Strict compare keeps earlier equal-cost paths ahead.
    assign hit = !valid_q || (cand_cost < cost_q);

    always_comb begin
        valid_d = valid_q;
        cost_d  = cost_q;
        path_d  = path_q;
        if (clr) begin
            valid_d = 1'b0;
            cost_d  = COST_MAX;
            path_d  = '0;
        end else if (en) begin
            if (prev_hit) begin
                valid_d = prev_valid;
                cost_d  = prev_cost;
                path_d  = prev_path;
            end else if (hit) begin
                valid_d = 1'b1;
                cost_d  = cand_cost;
                path_d  = cand_path;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            cost_q  <= COST_MAX;
            path_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cost_q  <= cost_d;
            path_q  <= path_d;
        end
    end

    assign valid = valid_q;
    assign cost  = cost_q;
    assign path  = path_q;

endmodule

// File: rtl/selection.sv
// Truncation selector: scans the population one path per cycle and
// keeps the N_SEL lowest-cost paths in a sorted slot chain.
module selection
    import ga_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    selection_if.slave bus
);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              clr;
    logic              en;

    logic [PATH_W-1:0] pop_a  [N_POP];
    logic [COST_W-1:0] cost_a [N_POP];
    logic [PATH_W-1:0] cand_path;
    logic [COST_W-1:0] cand_cost;

    logic              slot_hit   [N_SEL];
    logic              slot_valid [N_SEL];
    logic [COST_W-1:0] slot_cost  [N_SEL];
    logic [PATH_W-1:0] slot_path  [N_SEL];
    logic              prev_hit   [N_SEL];
    logic              prev_valid [N_SEL];
    logic [COST_W-1:0] prev_cost  [N_SEL];
    logic [PATH_W-1:0] prev_path  [N_SEL];
    logic              unused_tail;

    for (genvar i = 0; i < N_POP; i++) begin : g_unpack
        assign pop_a[i]  = bus.population[i*PATH_W +: PATH_W];
        assign cost_a[i] = bus.cost[i*COST_W +: COST_W];
    end

    assign cand_path = pop_a[idx_q];
    assign cand_cost = cost_a[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SCAN;
                    idx_d   = '0;
                    clr     = 1'b1;
                end
            end
            ST_SCAN: begin
                en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    for (genvar k = 0; k < N_SEL; k++) begin : g_slot
        if (k == 0) begin : g_head
            assign prev_hit[k]   = 1'b0;
            assign prev_valid[k] = 1'b0;
            assign prev_cost[k]  = COST_MAX;
            assign prev_path[k]  = '0;
        end else begin : g_link
            assign prev_hit[k]   = slot_hit[k-1];
            assign prev_valid[k] = slot_valid[k-1];
            assign prev_cost[k]  = slot_cost[k-1];
            assign prev_path[k]  = slot_path[k-1];
        end

        topk_slot u_slot (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .en         (en),
            .cand_cost  (cand_cost),
            .cand_path  (cand_path),
            .prev_hit   (prev_hit[k]),
            .prev_valid (prev_valid[k]),
            .prev_cost  (prev_cost[k]),
            .prev_path  (prev_path[k]),
            .hit        (slot_hit[k]),
            .valid      (slot_valid[k]),
            .cost       (slot_cost[k]),
            .path       (slot_path[k])
        );

        assign bus.sel_cost[k*COST_W +: COST_W]       = slot_cost[k];
        assign bus.sel_population[k*PATH_W +: PATH_W] = slot_path[k];
    end

    // The last slot has no lower neighbour to feed.
    assign unused_tail = slot_hit[N_SEL-1] ^ slot_valid[N_SEL-1];

    assign bus.done = done_q;

endmodule

// File: tb/tb_selection.sv
// Scoreboard bench for the truncation selector.
module tb_selection;
    import ga_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    selection_if bus ();

    selection dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [N_SEL*COST_W-1:0] c;
        logic [N_SEL*PATH_W-1:0] p;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    logic [COST_W-1:0] c_a [N_POP];
    logic [PATH_W-1:0] p_a [N_POP];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ascending, 1 descending, 2 all max, 3 random dups, 4 extremes
    task automatic load(input int mode);
        exp_t e;
        int   r;
        for (int i = 0; i < N_POP; i++) begin
            p_a[i] = PATH_W'({$urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom()});
            case (mode)
                0: c_a[i] = COST_W'(i);
                1: c_a[i] = COST_W'(N_POP - 1 - i);
                2: c_a[i] = COST_MAX;
                3: c_a[i] = COST_W'($urandom_range(0, 15));
                default: begin
                    case ($urandom_range(0, 2))
                        0: c_a[i] = 16'h0000;
                        1: c_a[i] = 16'hFFFE;
                        default: c_a[i] = 16'hFFFF;
                    endcase
                end
            endcase
            bus.population[i*PATH_W +: PATH_W] = p_a[i];
            bus.cost[i*COST_W +: COST_W]       = c_a[i];
        end
        // Stable rank: strictly cheaper paths plus earlier equal ones.
        e = '0;
        for (int i = 0; i < N_POP; i++) begin
            r = 0;
            for (int j = 0; j < N_POP; j++)
                if (c_a[j] < c_a[i] || (c_a[j] == c_a[i] && j < i))
                    r++;
            if (r < N_SEL) begin
                e.c[r*COST_W +: COST_W] = c_a[i];
                e.p[r*PATH_W +: PATH_W] = p_a[i];
            end
        end
        sb.push_back(e);
    endtask

    task automatic check_out(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_sb: done seen with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < N_SEL; k++) begin
            checks++;
            if (bus.sel_cost[k*COST_W +: COST_W] !== e.c[k*COST_W +: COST_W]) begin
                errors++;
                $display("FAIL %s_cost[%0d]: got %h want %h", name, k,
                         bus.sel_cost[k*COST_W +: COST_W], e.c[k*COST_W +: COST_W]);
            end
            checks++;
            if (bus.sel_population[k*PATH_W +: PATH_W] !== e.p[k*PATH_W +: PATH_W]) begin
                errors++;
                $display("FAIL %s_path[%0d]: got %h want %h", name, k,
                         bus.sel_population[k*PATH_W +: PATH_W],
                         e.p[k*PATH_W +: PATH_W]);
            end
        end
    endtask

    // Starts (or continues, with hold) a pass and checks latency, outputs
    // and the single-cycle done pulse.
    task automatic run_pass(input string name, input bit hold,
                            input int pa, input int pb);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        bus.start = 1'b1;
        while (!seen && n < 200) begin
            step();
            n++;
            if (!hold) bus.start = (n == pa) || (n == pb);
            seen = bus.done;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, n);
            if (sb.size() > 0) void'(sb.pop_front());
        end else begin
            checks++;
            if (n !== 51) begin
                errors++;
                $display("FAIL %s_latency: got %0d want 51", name, n);
            end
            check_out(name);
            step();
            checks++;
            if (bus.done !== 1'b0) begin
                errors++;
                $display("FAIL %s_pulse: done got %b want 0", name, bus.done);
            end
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: got %b want 0", name, bus.done);
        end
        checks++;
        if (bus.sel_cost !== {N_SEL{COST_MAX}}) begin
            errors++;
            $display("FAIL %s_cost: got %h want all ones", name, bus.sel_cost);
        end
        checks++;
        if (bus.sel_population !== '0) begin
            errors++;
            $display("FAIL %s_pop: got %h want 0", name, bus.sel_population);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_cleared("reset");
    endtask

    task automatic test_ascending();
        load(0);
        run_pass("ascending", 1'b0, 0, 0);
    endtask

    task automatic test_descending();
        load(1);
        run_pass("descending", 1'b0, 0, 0);
    endtask

    task automatic test_all_max();
        load(2);
        run_pass("all_max", 1'b0, 0, 0);
    endtask

    task automatic test_random_ignore_start();
        load(3);
        run_pass("rand_ignore", 1'b0, 5, 30);
        load(4);
        run_pass("extremes", 1'b0, 0, 0);
    endtask

    task automatic test_hold_idle();
        exp_t e;
        load(3);
        e = sb[0];
        run_pass("hold_pass", 1'b0, 0, 0);
        sb.push_back(e);
        for (int i = 0; i < 5; i++) step();
        check_out("hold_idle");
    endtask

    task automatic test_reset_mid();
        bit seen;
        load(3);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 1; i < 20; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        void'(sb.pop_back());
        check_cleared("mid_reset");
        seen = 1'b0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_reset_nodone: got done=1 want none");
        end
        load(3);
        run_pass("after_reset", 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back();
        load(3);
        run_pass("b2b_0", 1'b1, 0, 0);
        load(1);
        run_pass("b2b_1", 1'b1, 0, 0);
        load(4);
        run_pass("b2b_2", 1'b1, 0, 0);
        bus.start = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.population = '0;
        bus.cost = '0;
        test_reset();
        test_ascending();
        test_descending();
        test_all_max();
        test_random_ignore_start();
        test_hold_idle();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/selection.md
# selection

Tournament-free truncation selector for the genetic path optimiser: scans the full 50-path population with per-path costs and keeps the 10 lowest-cost paths. Produces the 1500-bit selected population consumed by the mutation stage, so it sits directly upstream of mutation in the generation loop. Uses the same start/done handshake as the other GA stages.

## Interface
- PATH_W, 150: bits per path.
- N_POP, 50: paths in the incoming population.
- N_SEL, 10: paths kept.
- COST_W, 16: unsigned cost per path; lower is fitter.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one selection pass; honoured only in IDLE.
- population  in  N_POP*PATH_W (7500)  path i at bits [i*150 +: 150].
- cost  in  N_POP*COST_W (800)  cost of path i at bits [i*16 +: 16].
- sel_population  out  N_SEL*PATH_W (1500)  slot k at [k*150 +: 150]; slot 0 has the lowest cost.
- sel_cost  out  N_SEL*COST_W (160)  cost of each slot, same ordering.
- done  out  1  one-cycle pulse when the outputs are final.

## Operation
- States: IDLE (0), SCAN (1), DONE (2). Encoding 3 is illegal and goes to IDLE.
- IDLE:
  - start=1 → SCAN.
  - On acceptance: index ← 0, all slot valid bits ← 0, sel_cost ← all ones, sel_population ← 0.
- SCAN processes one path per cycle, index 0..49:
  - Candidate is population[index] with cost[index].
  - Insertion position p = the first slot k where either valid[k]=0, or cost < sel_cost[k] (strict).
  - Slots p..8 shift to p+1..9. The old slot 9 is discarded. The candidate is written to p with valid=1.
  - If no such slot exists, the candidate is dropped.
  - Index 49 processed → DONE; otherwise index+1.
- Ties: strict less-than keeps earlier-index paths ahead of later equal-cost paths, so the result is deterministic.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- Output holding:
  - sel_population and sel_cost hold their values in IDLE until the next accepted start.
  - The mutation stage may sample them any time after done.
- start asserted in SCAN or DONE is ignored; it is not queued.
- population and cost are not latched. The driver holds them stable from the start cycle through done.
- Cost arithmetic: unsigned compare only; no adders. Cost 16'hFFFF is legal; a slot whose valid bit is clear accepts any cost.
- rst, at any time including mid-SCAN:
  - state ← IDLE, index ← 0, valid ← 0.
  - sel_cost ← all ones, sel_population ← 0, done ← 0.
  - The aborted pass produces no done.

## Timing
- Cycle 0: start sampled high in IDLE.
- Cycles 1..50: SCAN, processing indices 0..49.
- Cycle 51: done=1, outputs final.
- Cycle 52: back in IDLE. Earliest next start is sampled at cycle 52.
- Start-to-done latency is 51 cycles. Throughput is one pass per 52 cycles.
- Outputs are registered. Slot contents change only on SCAN cycles.
- Critical path: one 50:1 mux of 166 bits, then 10 parallel 16-bit compares, then the priority encode.

## Structure
- Shared package ga_pkg holds:
  - constants PATH_W, N_POP, N_SEL, COST_W;
  - the state encoding (ST_IDLE, ST_SCAN, ST_DONE);
  - COST_MAX.
  - The mutation stage and other GA stages import the same package.
- Sub-module topk_slot, instantiated N_SEL times as a chain. Each slot:
  - holds valid, cost and path;
  - compares against the candidate;
  - takes the candidate, its upper neighbour's contents, or holds, depending on its own and its neighbour's compare result.
- The top level contains the FSM, the index counter, the candidate mux and the output packing.
- Expected size is about 200 lines.

## Test plan
- Ascending costs: cost[i]=i.
  - done occurs 51 cycles after start.
  - Slots 0..9 hold paths 0..9 with sel_cost 0..9.
- Descending costs: cost[i]=49-i.
  - Slot 0 holds path 49 (cost 0) and slot 9 holds path 40 (cost 9).
- All costs equal to 16'hFFFF.
  - Slots hold paths 0..9 in order, which checks the empty-slot rule and the tie rule.
- Random costs with duplicates, compared against a software model that sorts stably and takes the first 10.
  - Outputs match exactly.
  - start pulsed at cycles 5 and 30 of the scan is ignored, and done still occurs at cycle 51.
- rst asserted at scan cycle 20:
  - Next cycle is IDLE, sel_cost is all ones, sel_population is 0, and no done pulse occurs.
  - A new start then completes normally with correct results.
- Back-to-back passes:
  - start held high continuously gives done every 52 cycles.
  - Each pass's outputs reflect that pass's inputs only.
